// File: rtl/hazard_pkg.sv
// Shared types and constants for the decode-stage hazard scoreboard.
// Build option: HAZARD_PERF_EN adds the saturating stall-cycle counter.
package hazard_pkg;

    localparam int REG_AW_DEF = 5;
    // Slot rd storage width; REG_AW of an instance must not exceed this.
    localparam int SLOT_AW    = 8;

    localparam logic [1:0] CAUSE_NONE   = 2'b00;
    localparam logic [1:0] CAUSE_PIPE   = 2'b01;
    localparam logic [1:0] CAUSE_LONG   = 2'b10;
    localparam logic [1:0] CAUSE_STRUCT = 2'b11;

    typedef struct packed {
        logic               valid;
        logic [SLOT_AW-1:0] rd;
        logic               load;
    } slot_t;

endpackage

// File: rtl/hazard_long_tracker.sv
// Long-latency unit tracker: busy countdown, pending destination and the
// RAW/WAW compare of the ID instruction against that destination.
module hazard_long_tracker #(
    parameter int REG_AW   = 5,
    parameter int LONG_LAT = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              issue,
    input  logic              id_use_rs,
    input  logic [REG_AW-1:0] id_rs,
    input  logic              id_use_rt,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_we,
    input  logic [REG_AW-1:0] id_rd,
    output logic              busy,
    output logic              hazard
);
    localparam int CW = $clog2(LONG_LAT + 1);

    logic [CW-1:0]     cnt;
    logic [REG_AW-1:0] long_rd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            long_rd <= '0;
        end else if (issue) begin
            cnt     <= CW'(LONG_LAT);
            // A long op without a writeback never creates a data hazard.
            long_rd <= id_we ? id_rd : '0;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign busy   = (cnt != '0);
    assign hazard = busy && (long_rd != '0) &&
                    ((id_use_rs && id_rs == long_rd) ||
                     (id_use_rt && id_rt == long_rd) ||
                     (id_we     && id_rd == long_rd));

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard unit: in-flight destination slots plus one long-latency
// unit. Build option HAZARD_PERF_EN adds perf_stall_cnt.
module hazard_scoreboard import hazard_pkg::*; #(
    parameter int REG_AW   = REG_AW_DEF,
    parameter int DEPTH    = 3,
    parameter int FORWARD  = 1,
    parameter int LONG_LAT = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              id_we,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_load,
    input  logic              id_long,
    input  logic              flush,
    output logic              stall,
    output logic [1:0]        stall_cause,
    output logic              long_busy
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]       perf_stall_cnt
`endif
);
    slot_t [DEPTH-1:0]  slots;
    logic  [DEPTH-1:0]  slot_hit;
    logic [SLOT_AW-1:0] rs_x, rt_x, rd_x;
    logic               accept, pipe_raw, long_haz, struct_haz;
    logic               unused_tail;

    assign rs_x = SLOT_AW'(id_rs);
    assign rt_x = SLOT_AW'(id_rt);
    assign rd_x = SLOT_AW'(id_rd);
    assign unused_tail = slots[DEPTH-1].load;

    // With forwarding only a load sitting in EX cannot be bypassed in time.
    for (genvar k = 0; k < DEPTH; k++) begin : g_slot
        logic match;
        assign match = slots[k].valid &&
                       ((id_use_rs && rs_x != '0 && rs_x == slots[k].rd) ||
                        (id_use_rt && rt_x != '0 && rt_x == slots[k].rd));
        if (FORWARD != 0) begin : g_fwd
            if (k == 0) begin : g_ex
                assign slot_hit[k] = match && slots[k].load;
            end else begin : g_late
                assign slot_hit[k] = 1'b0;
            end
        end else begin : g_nofwd
            assign slot_hit[k] = match;
        end
    end

    assign pipe_raw = |slot_hit;

    hazard_long_tracker #(.REG_AW(REG_AW), .LONG_LAT(LONG_LAT)) u_long (
        .clk       (clk),
        .rst_n     (rst_n),
        .issue     (accept && id_long),
        .id_use_rs (id_use_rs),
        .id_rs     (id_rs),
        .id_use_rt (id_use_rt),
        .id_rt     (id_rt),
        .id_we     (id_we),
        .id_rd     (id_rd),
        .busy      (long_busy),
        .hazard    (long_haz)
    );

    assign struct_haz = long_busy && id_long;
    assign stall      = id_valid && !flush && (pipe_raw || long_haz || struct_haz);
    assign accept     = id_valid && !stall && !flush;

    always_comb begin
        stall_cause = CAUSE_NONE;
        if (stall) begin
            if (struct_haz)    stall_cause = CAUSE_STRUCT;
            else if (long_haz) stall_cause = CAUSE_LONG;
            else               stall_cause = CAUSE_PIPE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slots <= '0;
        end else begin
            slots[0] <= '{valid: accept && id_we && !id_long && id_rd != '0,
                          rd:    rd_x,
                          load:  id_load};
            for (int k = 1; k < DEPTH; k++) slots[k] <= slots[k-1];
        end
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                  perf_stall_cnt <= '0;
        else if (stall && perf_stall_cnt != '1)      perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench: one forwarding instance and one non-forwarding instance
// share the ID inputs; each scenario checks the instance it targets.
module tb_hazard_scoreboard;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       id_valid, id_use_rs, id_use_rt, id_we, id_load, id_long, flush;
    logic [4:0] id_rs, id_rt, id_rd;
    logic       stall_f, busy_f, stall_n, busy_n;
    logic [1:0] cause_f, cause_n;
`ifdef HAZARD_PERF_EN
    logic [31:0] perf_f, perf_n;
`endif
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    hazard_scoreboard #(.REG_AW(5), .DEPTH(3), .FORWARD(1), .LONG_LAT(8)) u_f (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_we(id_we), .id_rd(id_rd),
        .id_load(id_load), .id_long(id_long), .flush(flush),
        .stall(stall_f), .stall_cause(cause_f), .long_busy(busy_f)
`ifdef HAZARD_PERF_EN
        , .perf_stall_cnt(perf_f)
`endif
    );

    hazard_scoreboard #(.REG_AW(5), .DEPTH(3), .FORWARD(0), .LONG_LAT(8)) u_n (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_we(id_we), .id_rd(id_rd),
        .id_load(id_load), .id_long(id_long), .flush(flush),
        .stall(stall_n), .stall_cause(cause_n), .long_busy(busy_n)
`ifdef HAZARD_PERF_EN
        , .perf_stall_cnt(perf_n)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // valid, rs, use_rs, rt, use_rt, we, rd, load, long, flush
    task automatic drive(input logic v, input logic [4:0] rs, input logic urs,
                         input logic [4:0] rt, input logic urt, input logic we,
                         input logic [4:0] rd, input logic ld, input logic lg,
                         input logic fl);
        id_valid = v; id_rs = rs; id_use_rs = urs; id_rt = rt; id_use_rt = urt;
        id_we = we; id_rd = rd; id_load = ld; id_long = lg; flush = fl;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic edge_step();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        idle();
        #1;
        chk("rst_stall_f", stall_f, 0);
        chk("rst_cause_f", cause_f, 0);
        chk("rst_busy_f",  busy_f,  0);
        chk("rst_stall_n", stall_n, 0);
`ifdef HAZARD_PERF_EN
        chk("rst_perf", perf_f, 0);
`endif
        do_reset();

        // load-use with forwarding: one bubble, then accepted
        drive(1, 0, 0, 0, 0, 1, 5, 1, 0, 0);            // lw r5
        @(negedge clk); chk("lw_issue_stall", stall_f, 0);
        edge_step();
        drive(1, 5, 1, 1, 1, 1, 6, 0, 0, 0);            // add r6,r5,r1
        @(negedge clk);
        chk("lu_stall",  stall_f, 1);
        chk("lu_cause",  cause_f, 1);
        edge_step();
        @(negedge clk);
        chk("lu_release", stall_f, 0);
        chk("lu_rel_cause", cause_f, 0);
        edge_step();

        // no forwarding: ALU result stalls for DEPTH cycles
        do_reset();
        drive(1, 0, 0, 0, 0, 1, 5, 0, 0, 0);            // add r5
        edge_step();
        drive(1, 5, 1, 0, 0, 1, 6, 0, 0, 0);
        @(negedge clk);
        chk("alu_fwd_nostall", stall_f, 0);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("nofwd_stall%0d", i), stall_n, 1);
            chk($sformatf("nofwd_cause%0d", i), cause_n, 1);
            edge_step();
            @(negedge clk);
        end
        chk("nofwd_release", stall_n, 0);
        edge_step();

        // long RAW / WAW / unrelated
        do_reset();
        drive(1, 0, 0, 0, 0, 1, 7, 0, 1, 0);            // mul r7
        @(negedge clk); chk("mul_issue", stall_f, 0);
        edge_step();
        drive(1, 7, 1, 0, 0, 1, 8, 0, 0, 0);            // reads r7
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("long_raw%0d", i), stall_f, 1);
            chk($sformatf("long_cause%0d", i), cause_f, 2);
            if (i == 2) begin
                #1 drive(1, 0, 0, 0, 0, 1, 7, 0, 0, 0); // WAW on r7
                #1 chk("long_waw", cause_f, 2);
                drive(1, 1, 1, 2, 1, 1, 8, 0, 0, 0);    // add r8,r1,r2
                #1 chk("long_unrel", stall_f, 0);
                chk("long_busy_mid", busy_f, 1);
                drive(1, 7, 1, 0, 0, 1, 8, 0, 0, 0);
            end
            edge_step();
            @(negedge clk);
        end
        chk("long_release", stall_f, 0);
        chk("long_idle", busy_f, 0);
`ifdef HAZARD_PERF_EN
        chk("perf_count", perf_f, 8);
`endif
        edge_step();

        // structural: second long op waits for the unit
        do_reset();
        drive(1, 0, 0, 0, 0, 1, 7, 0, 1, 0);
        edge_step();
        drive(1, 1, 1, 2, 1, 1, 9, 0, 1, 0);            // div r9,r1,r2
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("struct_cause%0d", i), cause_f, 3);
            edge_step();
            @(negedge clk);
        end
        chk("struct_release", stall_f, 0);
        edge_step();
        idle();
        @(negedge clk);
        chk("div_busy", busy_f, 1);

        // flush over a load-use, then r0 never hazards
        do_reset();
        drive(1, 0, 0, 0, 0, 1, 5, 1, 0, 0);
        edge_step();
        drive(1, 5, 1, 1, 1, 1, 6, 0, 0, 1);
        @(negedge clk);
        chk("flush_stall", stall_f, 0);
        chk("flush_cause", cause_f, 0);
        edge_step();
        drive(1, 6, 1, 0, 0, 0, 0, 0, 0, 0);            // reads r6
        @(negedge clk);
        chk("flush_bubble", stall_n, 0);
        edge_step();
        do_reset();
        drive(1, 0, 0, 0, 0, 1, 0, 1, 0, 0);            // lw r0
        edge_step();
        drive(1, 0, 1, 0, 1, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("r0_fwd", stall_f, 0);
        chk("r0_nofwd", stall_n, 0);
        edge_step();

        // async reset during a long op
        do_reset();
        drive(1, 0, 0, 0, 0, 1, 7, 0, 1, 0);
        edge_step();
        idle();
        repeat (4) edge_step();
        drive(1, 7, 1, 0, 0, 1, 8, 0, 0, 0);
        #1 chk("mid_busy", busy_f, 1);
        chk("mid_stall", stall_f, 1);
        rst_n = 1'b0;
        #1 chk("arst_busy", busy_f, 0);
        chk("arst_stall", stall_f, 0);
`ifdef HAZARD_PERF_EN
        chk("arst_perf", perf_f, 0);
`endif
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_stall", stall_f, 0);
        chk("post_rst_busy", busy_f, 0);
        idle();
        edge_step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
